// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: state encoding, HALT opcode and opcode-field slice.
package fetch_pkg;

    localparam int unsigned NB_INSTRUCTION_DEF = 16;
    localparam int unsigned NB_ADDR_DEF        = 10;
    localparam int unsigned NB_OPCODE_DEF      = 5;
    localparam int unsigned NB_CYCLES_DEF      = 32;

    // Opcode lives in the instruction MSBs
    localparam int unsigned OPCODE_MSB = NB_INSTRUCTION_DEF - 1;
    localparam int unsigned OPCODE_LSB = NB_INSTRUCTION_DEF - NB_OPCODE_DEF;

    localparam logic [NB_OPCODE_DEF-1:0] HALT_OPCODE = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: program ROM read port plus the valid/ready link to the decoder.
interface instr_fetch_unit_if #(
    parameter int unsigned NB_INSTRUCTION = 16,
    parameter int unsigned NB_ADDR        = 10
) ();
    logic [NB_ADDR-1:0]        o_rom_addr;
    logic [NB_INSTRUCTION-1:0] i_rom_data;
    logic [NB_INSTRUCTION-1:0] o_instr;
    logic                      o_instr_valid;
    logic                      i_instr_ready;
    logic [NB_ADDR-1:0]        o_pc;

    modport master (
        output o_rom_addr,
        input  i_rom_data,
        output o_instr,
        output o_instr_valid,
        input  i_instr_ready,
        output o_pc
    );

    modport slave (
        input  o_rom_addr,
        output i_rom_data,
        input  o_instr,
        input  o_instr_valid,
        output i_instr_ready,
        input  o_pc
    );
endinterface

// File: rtl/instr_fetch_unit_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
    parameter int unsigned NB_COUNT = 32
) (
    input  logic                i_clock,
    input  logic                i_clear_n,
    input  logic                i_enable,
    output logic [NB_COUNT-1:0] o_count
);
    logic [NB_COUNT-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (!i_clear_n) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + NB_COUNT'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// PC / fetch stage: reads the program ROM, registers each word and hands it to the decoder.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned NB_INSTRUCTION = NB_INSTRUCTION_DEF,
    parameter int unsigned NB_ADDR        = NB_ADDR_DEF,
    parameter int unsigned NB_OPCODE      = NB_OPCODE_DEF,
    parameter int unsigned NB_CYCLES      = NB_CYCLES_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    instr_fetch_unit_if.master      fetch_bus,
    output logic                    o_halted,
    output logic                    o_pc_overflow,
    output logic [NB_CYCLES-1:0]    o_cycle_count
);
    localparam logic [NB_ADDR-1:0] PC_LAST = '1;

    fetch_state_e              r_state;
    logic [NB_ADDR-1:0]        r_pc;
    logic [NB_ADDR-1:0]        r_pc_out;
    logic [NB_INSTRUCTION-1:0] r_instr;
    logic                      r_valid;
    logic                      r_halted;
    logic                      r_overflow;

    logic [NB_OPCODE-1:0]      w_opcode;
    logic                      w_is_halt;
    logic                      w_run;
    logic                      w_capture;

    assign w_opcode  = fetch_bus.i_rom_data[NB_INSTRUCTION-1 -: NB_OPCODE];
    assign w_is_halt = (w_opcode == NB_OPCODE'(HALT_OPCODE));
    assign w_run     = (r_state == ST_RUN);
    // Output register is free, or its contents leave on this edge
    assign w_capture = w_run && (!r_valid || fetch_bus.i_instr_ready);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_pc_out   <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_capture) begin
                        r_instr  <= fetch_bus.i_rom_data;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        if (w_is_halt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (r_pc == PC_LAST) begin
                            r_state    <= ST_HALT;
                            r_halted   <= 1'b1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_pc <= r_pc + NB_ADDR'(1);
                        end
                    end
                end
                ST_HALT: begin
                    // Drain the last delivered instruction; only reset leaves HALT
                    if (r_valid && fetch_bus.i_instr_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .NB_COUNT (NB_CYCLES)
    ) u_cycle_counter (
        .i_clock   (i_clock),
        .i_clear_n (i_reset),
        .i_enable  (w_run),
        .o_count   (o_cycle_count)
    );

    assign fetch_bus.o_rom_addr    = r_pc;
    assign fetch_bus.o_instr       = r_instr;
    assign fetch_bus.o_instr_valid = r_valid;
    assign fetch_bus.o_pc          = r_pc_out;
    assign o_halted                = r_halted;
    assign o_pc_overflow           = r_overflow;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed programs plus random programs/backpressure against a transaction model.
module tb_instr_fetch_unit;
    localparam int unsigned TB_NI    = 16;
    localparam int unsigned TB_NA    = 4;
    localparam int unsigned TB_NO    = 5;
    localparam int unsigned TB_NC    = 3;
    localparam int          DEPTH    = 16;
    localparam int          CNT_MAX  = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             start;
    logic             ready;
    logic             halted;
    logic             ovf;
    logic [TB_NC-1:0] cyc;
    logic [TB_NI-1:0] rom [DEPTH];

    instr_fetch_unit_if #(.NB_INSTRUCTION(TB_NI), .NB_ADDR(TB_NA)) bus ();

    assign bus.i_rom_data    = rom[bus.o_rom_addr];
    assign bus.i_instr_ready = ready;

    instr_fetch_unit #(
        .NB_INSTRUCTION (TB_NI),
        .NB_ADDR        (TB_NA),
        .NB_OPCODE      (TB_NO),
        .NB_CYCLES      (TB_NC)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .fetch_bus     (bus),
        .o_halted      (halted),
        .o_pc_overflow (ovf),
        .o_cycle_count (cyc)
    );

    int checks   = 0;
    int failures = 0;

    // Program-level expectation: words delivered are addresses 0..n_exp-1
    int          n_exp;
    bit          exp_ovf;
    // Transaction model of the unit as seen from outside
    bit          m_run, m_halt, m_pend, m_ovf;
    int          m_idx, m_pc, m_count, stall_cnt;
    logic [15:0] m_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void compute_expected();
        n_exp   = DEPTH;
        exp_ovf = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            if (rom[a][15:11] == 5'd0) begin
                n_exp   = a + 1;
                exp_ovf = 1'b0;
                break;
            end
        end
    endfunction

    function automatic void model_reset();
        m_run = 0; m_halt = 0; m_pend = 0; m_ovf = 0;
        m_idx = 0; m_pc = 0; m_count = 0; stall_cnt = 0;
        m_instr = '0;
    endfunction

    // Advance the model across one rising edge with the given inputs
    function automatic void model_edge(input bit s, input bit r);
        if (m_run) begin
            if (m_count < CNT_MAX) m_count++;
            if (!m_pend || r) begin
                m_pend  = 1;
                m_instr = rom[m_idx];
                m_pc    = m_idx;
                if (m_idx == n_exp - 1) begin
                    m_run  = 0;
                    m_halt = 1;
                    m_ovf  = exp_ovf;
                end else begin
                    m_idx++;
                end
            end
        end else if (m_halt) begin
            if (m_pend && r) m_pend = 0;
        end else if (s) begin
            m_run = 1;
        end
    endfunction

    task automatic check_all();
        check("valid",     32'(bus.o_instr_valid), 32'(m_pend));
        check("rom_addr",  32'(bus.o_rom_addr),    32'(m_idx));
        check("halted",    32'(halted),            32'(m_halt));
        check("overflow",  32'(ovf),               32'(m_ovf));
        check("cycles",    32'(cyc),               32'(m_count));
        if (m_pend) begin
            check("instr", 32'(bus.o_instr), 32'(m_instr));
            check("pc",    32'(bus.o_pc),    32'(m_pc));
        end
    endtask

    function automatic bit pick_ready(input int mode);
        bit r;
        case (mode)
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            default: r = (stall_cnt >= 4);
        endcase
        if (m_pend && !r) stall_cnt++;
        return r;
    endfunction

    task automatic fill_random(input bit allow_halt);
        logic [15:0] w;
        for (int a = 0; a < DEPTH; a++) begin
            w = 16'($urandom);
            if (allow_halt && ($urandom_range(0, 5) == 0)) w[15:11] = 5'd0;
            else w[15:11] = 5'($urandom_range(1, 31));
            rom[a] = w;
        end
    endtask

    task automatic load_demo();
        fill_random(1'b0);
        rom[0] = 16'h0801;
        rom[1] = 16'h1802;
        rom[2] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'($urandom_range(0, 1));
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    // Start from IDLE and run until the program drains, then poke i_start in HALT
    task automatic run_prog(input int mode);
        int n;
        compute_expected();
        @(negedge clk);
        check_all();
        start = 1'b1;
        ready = pick_ready(mode);
        model_edge(start, ready);
        n = 0;
        while (!(m_halt && !m_pend) && n < 300) begin
            @(negedge clk);
            check_all();
            start = 1'($urandom_range(0, 1));
            ready = pick_ready(mode);
            model_edge(start, ready);
            n++;
        end
        check("drained", 32'(m_halt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_all();
            start = (k % 2 == 0);
            ready = 1'($urandom_range(0, 1));
            model_edge(start, ready);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        load_demo();
        compute_expected();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Demo program, full throughput
        load_demo();
        run_prog(0);
        check("demo_cycles", 32'(cyc), 32'd3);
        check("demo_addr",   32'(bus.o_rom_addr), 32'd2);
        do_reset();

        // Demo program with four stall cycles on the first word
        load_demo();
        run_prog(2);
        do_reset();

        // No HALT anywhere: walks off the end and saturates the cycle counter
        fill_random(1'b0);
        run_prog(0);
        check("ovf_flag",  32'(ovf), 32'd1);
        check("ovf_pc",    32'(bus.o_rom_addr), 32'(DEPTH - 1));
        check("sat_count", 32'(cyc), 32'(CNT_MAX));
        do_reset();

        // Reset while an instruction is pending and stalled, then restart
        load_demo();
        compute_expected();
        @(negedge clk);
        check_all();
        start = 1'b1;
        ready = 1'b0;
        model_edge(start, ready);
        for (int k = 0; k < 3 && !m_pend; k++) begin
            @(negedge clk);
            check_all();
            start = 1'b0;
            ready = 1'b0;
            model_edge(start, ready);
        end
        check("pending_before_reset", 32'(m_pend), 32'd1);
        do_reset();
        run_prog(1);
        do_reset();

        // Random programs with random backpressure
        for (int t = 0; t < 8; t++) begin
            fill_random(1'b1);
            run_prog(1);
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
